interrupt_controller: RTL and testbench

Interrupt source for the microprogrammed CPU: collects external interrupt requests, masks and prioritises them, and drives the single `int` line that the control unit samples between instructions. It is the responder side of that line. It holds `int` until the control unit acknowledges, then exposes the handler vector and stays in service until the microcode signals return-from-interrupt. There is no nesting: one interrupt is in service at a time.

---
 rtl/interrupt_controller_pkg.sv | 28 ++
 rtl/interrupt_controller_if.sv | 38 +++
 rtl/interrupt_controller_prio_enc.sv | 27 ++
 rtl/interrupt_controller.sv | 109 ++++++++++
 tb/tb_interrupt_controller.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared types and defaults for the interrupt controller
//
// Package intc_pkg:
//   IDLE/REQ/SERVICE  state encodings, and the state_t enum built from them
//   DEF_N_SRC         default number of interrupt sources
//   DEF_VEC_BASE      default vector of source 0
//   vec_of()          handler vector for a source index, 8-bit wraparound
package intc_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_REQ     = REQ,
    ST_SERVICE = SERVICE
  } state_t;

  localparam int         DEF_N_SRC    = 4;
  localparam logic [7:0] DEF_VEC_BASE = 8'hF0;

  // The sum wraps in 8 bits, so a large base plus a high index truncates.
  function automatic logic [7:0] vec_of(input logic [7:0] base, input logic [2:0] idx);
    return base + {5'd0, idx};
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - request/acknowledge bundle between the CPU side and the controller
//
// Signals:
//   irq[N_SRC]       request lines, rising-edge sensitive
//   mask_we          mask register write enable
//   mask_din[N_SRC]  new mask value, 1 = source enabled
//   inta             interrupt acknowledge from the control unit
//   iret             return-from-interrupt from the control unit
//   intr             interrupt request to the control unit (the "int" line)
//   vector[8]        handler vector, valid while in_service
//   in_service       a handler is active
//   pending[N_SRC]   latched unserviced edges
// Modports: master drives requests and microcode fields, slave is the controller.
interface interrupt_controller_if #(
  parameter int N_SRC = intc_pkg::DEF_N_SRC
);

  logic [N_SRC-1:0] irq;
  logic             mask_we;
  logic [N_SRC-1:0] mask_din;
  logic             inta;
  logic             iret;
  logic             intr;
  logic [7:0]       vector;
  logic             in_service;
  logic [N_SRC-1:0] pending;

  modport master (
    output irq, mask_we, mask_din, inta, iret,
    input  intr, vector, in_service, pending
  );

  modport slave (
    input  irq, mask_we, mask_din, inta, iret,
    output intr, vector, in_service, pending
  );

endinterface

// File: rtl/interrupt_controller_prio_enc.sv
// rtl/interrupt_controller_prio_enc.sv - combinational lowest-index-wins priority encoder
//
// Ports:
//   req[N_SRC]  request vector
//   idx[3]      index of the lowest set bit, 0 when none is set
//   any         at least one bit of req is set
module prio_enc #(
  parameter int N_SRC = intc_pkg::DEF_N_SRC
) (
  input  logic [N_SRC-1:0] req,
  output logic [2:0]       idx,
  output logic             any
);

  // Scanning from the top down lets the lowest set index overwrite the rest.
  always_comb begin
    idx = 3'd0;
    any = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - masked, prioritised, non-nesting interrupt source for the CPU
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   interrupt_controller_if.slave: irq, mask_we, mask_din, inta, iret in;
//         intr, vector, in_service, pending out (all outputs registered)
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int         N_SRC    = DEF_N_SRC,
  parameter logic [7:0] VEC_BASE = DEF_VEC_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_controller_if.slave bus
);

  state_t           state;
  logic [2:0]       cur_idx;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] irq_q;
  logic             armed;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] clr;
  logic [2:0]       grant_idx;
  logic             any;

  // irq_q is zero out of reset, so a line that is already high would look
  // like a fresh edge on the first clock. 'armed' blanks detection for that
  // one clock while irq_q picks up the real line levels.
  assign rise = bus.irq & ~irq_q & {N_SRC{armed}};

  // Masked bits stay latched in pending; they simply do not request.
  assign req = bus.pending & mask;

  prio_enc #(
    .N_SRC(N_SRC)
  ) u_prio (
    .req(req),
    .idx(grant_idx),
    .any(any)
  );

  // Bit of pending retired by this clock's acknowledge.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = (state == ST_REQ) && bus.inta && (cur_idx == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cur_idx        <= 3'd0;
      mask           <= '1;
      irq_q          <= '0;
      armed          <= 1'b0;
      bus.pending    <= '0;
      bus.intr       <= 1'b0;
      bus.vector     <= 8'h00;
      bus.in_service <= 1'b0;
    end else begin
      irq_q <= bus.irq;
      armed <= 1'b1;

      if (bus.mask_we) begin
        mask <= bus.mask_din;
      end

      // A new edge on the bit being acknowledged wins over the clear.
      bus.pending <= (bus.pending & ~clr) | rise;

      case (state)
        ST_IDLE: begin
          if (any) begin
            state    <= ST_REQ;
            cur_idx  <= grant_idx;
            bus.intr <= 1'b1;
          end
        end
        // The request latched in cur_idx is held until acknowledged, even if
        // the mask changes or a higher-priority edge arrives meanwhile.
        ST_REQ: begin
          if (bus.inta) begin
            state          <= ST_SERVICE;
            bus.intr       <= 1'b0;
            bus.vector     <= vec_of(VEC_BASE, cur_idx);
            bus.in_service <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (bus.iret) begin
            state          <= ST_IDLE;
            bus.in_service <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          bus.intr       <= 1'b0;
          bus.in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - table-driven scoreboard bench for interrupt_controller
module tb_interrupt_controller;

  typedef struct {
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_din;
    logic       inta;
    logic       iret;
    logic       e_int;
    logic       e_ins;
    logic [7:0] e_vec;
    logic [3:0] e_pend;
  } vec_t;

  typedef struct {
    logic       e_int;
    logic       e_ins;
    logic [7:0] e_vec;
    logic [3:0] e_pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  interrupt_controller_if #(.N_SRC(4)) bus ();

  interrupt_controller #(
    .N_SRC(4),
    .VEC_BASE(8'hF0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] irq, input logic we, input logic [3:0] din,
                              input logic a, input logic r, input logic ei, input logic es,
                              input logic [7:0] ev, input logic [3:0] ep);
    vec_t v;
    v.irq = irq; v.mask_we = we; v.mask_din = din; v.inta = a; v.iret = r;
    v.e_int = ei; v.e_ins = es; v.e_vec = ev; v.e_pend = ep;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    bus.irq      = v.irq;
    bus.mask_we  = v.mask_we;
    bus.mask_din = v.mask_din;
    bus.inta     = v.inta;
    bus.iret     = v.iret;
    e.e_int = v.e_int; e.e_ins = v.e_ins; e.e_vec = v.e_vec; e.e_pend = v.e_pend;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".int"}, {7'd0, bus.intr}, {7'd0, e.e_int});
      chk({tag, ".in_service"}, {7'd0, bus.in_service}, {7'd0, e.e_ins});
      chk({tag, ".vector"}, bus.vector, e.e_vec);
      chk({tag, ".pending"}, {4'd0, bus.pending}, {4'd0, e.e_pend});
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    drive(v);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of test, expected finish before 50000");
    $fatal(1);
  end

  initial begin
    bus.irq = 4'd0; bus.mask_we = 1'b0; bus.mask_din = 4'd0; bus.inta = 1'b0; bus.iret = 1'b0;

    //              irq    we    din     inta  iret  int   ins   vec    pend
    // reset release and basic flow on source 2
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0100));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0100));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0100));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF2, 4'b0000));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF2, 4'b0000));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF2, 4'b0000));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF2, 4'b0000));
    // priority 1 over 3, no preemption by source 0 during service
    tbl.push_back(mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF2, 4'b1010));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF2, 4'b1010));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF1, 4'b1000));
    tbl.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF1, 4'b1001));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF1, 4'b1001));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF1, 4'b1001));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF1, 4'b1001));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF0, 4'b1000));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 4'b1000));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 4'b1000));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF3, 4'b0000));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF3, 4'b0000));
    // mask out source 0, then re-enable it
    tbl.push_back(mk(4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF3, 4'b0000));
    tbl.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF3, 4'b0001));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF3, 4'b0001));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF3, 4'b0001));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF3, 4'b0001));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF3, 4'b0001));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF0, 4'b0000));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 4'b0000));
    // inta in IDLE, iret in REQ, edge colliding with the acknowledge clear
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 4'b0000));
    tbl.push_back(mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 4'b0100));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 4'b0100));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 4'b0100));
    tbl.push_back(mk(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF2, 4'b0100));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF2, 4'b0100));

    // reset values while rst is held low
    repeat (3) @(posedge clk);
    #1;
    chk("reset.int", {7'd0, bus.intr}, 8'h00);
    chk("reset.in_service", {7'd0, bus.in_service}, 8'h00);
    chk("reset.vector", bus.vector, 8'h00);
    chk("reset.pending", {4'd0, bus.pending}, 8'h00);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("row%0d", i));
    end

    // asynchronous reset in SERVICE, checked before any clock edge can occur
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst.int", {7'd0, bus.intr}, 8'h00);
    chk("async_rst.in_service", {7'd0, bus.in_service}, 8'h00);
    chk("async_rst.vector", bus.vector, 8'h00);
    chk("async_rst.pending", {4'd0, bus.pending}, 8'h00);

    // irq[0] high across reset release must not register as an edge
    bus.irq = 4'b0001;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000), "held0");
    step(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000), "held1");
    step(mk(4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0010), "post_rst_edge");
    step(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0010), "post_rst_req");
    step(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF1, 4'b0000), "post_rst_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
